// File: rtl/dvi_frame_reader_if.sv
// Read-FIFO port bundle between the DDR2 frame buffer and the DVI-side frame reader.
interface dvi_frame_reader_if #(
  parameter int unsigned USEDW_W = 9
) ();
  logic [31:0]        fifo_data;
  logic               fifo_empty;
  logic [USEDW_W-1:0] fifo_rdusedw;
  logic               fifo_rdreq;

  modport master (output fifo_rdreq, input fifo_data, fifo_empty, fifo_rdusedw);
  modport slave  (input fifo_rdreq, output fifo_data, fifo_empty, fifo_rdusedw);
endinterface

// File: rtl/dvi_frame_reader.sv
// DVI-clock consumer of the frame buffer read FIFO: paces pops to vpg timing,
// realigns RGB with the delayed syncs, and recovers from underflow via prefill.
module dvi_frame_reader #(
  parameter int unsigned FRAME_SIZE = 640,
  parameter int unsigned PREFILL    = 512,
  parameter int unsigned USEDW_W    = 9
) (
  input  logic                dvi_clk,
  input  logic                reset,
  input  logic                vpg_de,
  input  logic                vpg_hs,
  input  logic                vpg_vs,
  dvi_frame_reader_if.master  fifo,
  output logic                read_init,
  output logic                out_de,
  output logic                out_hs,
  output logic                out_vs,
  output logic [23:0]         out_data,
  output logic [19:0]         pix_cnt,
  output logic [15:0]         frame_cnt,
  output logic                underflow,
  output logic [1:0]          state
);

  localparam int unsigned LVL_W = USEDW_W + 1;
  localparam int unsigned PIX_W = 20;
  localparam int unsigned FRM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_WAIT_VS = 2'd2,
    ST_ACTIVE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             read_init_q, read_init_d;
  logic             underflow_q, underflow_d;
  logic             vs_prev_q;
  logic             out_de_q, out_hs_q, out_vs_q;
  logic             rd_q;

  logic             vs_rise;
  logic             in_frame;
  logic             fifo_full;
  logic [LVL_W-1:0] fifo_level;
  logic             prefill_ok;
  logic             pop_c;
  logic             underrun_c;

  // A completely full FIFO reports rdusedw wrapped to 0; recover the true level.
  assign fifo_full  = (fifo.fifo_rdusedw == '0) && !fifo.fifo_empty;
  assign fifo_level = {fifo_full, fifo.fifo_rdusedw};
  assign prefill_ok = fifo_level >= LVL_W'(PREFILL);

  assign vs_rise    = vpg_vs & ~vs_prev_q;
  assign in_frame   = pix_cnt_q < PIX_W'(FRAME_SIZE);
  assign pop_c      = (state_q == ST_ACTIVE) & vpg_de & ~fifo.fifo_empty & in_frame & ~vs_rise;
  assign underrun_c = (state_q == ST_ACTIVE) & vpg_de &  fifo.fifo_empty & in_frame & ~vs_rise;

  assign fifo.fifo_rdreq = pop_c;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    frame_cnt_d = frame_cnt_q;
    read_init_d = 1'b0;
    underflow_d = underflow_q;
    case (state_q)
      ST_IDLE: begin
        read_init_d = 1'b1;
        state_d     = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (prefill_ok) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (vs_rise) begin
          pix_cnt_d = '0;
          state_d   = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          frame_cnt_d = frame_cnt_q + FRM_W'(1);
          pix_cnt_d   = '0;
          read_init_d = 1'b1;
        end else if (underrun_c) begin
          underflow_d = 1'b1;
          state_d     = ST_PREFILL;
        end else if (pop_c) begin
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge dvi_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      frame_cnt_q <= '0;
      read_init_q <= 1'b0;
      underflow_q <= 1'b0;
      vs_prev_q   <= 1'b0;
      out_de_q    <= 1'b0;
      out_hs_q    <= 1'b0;
      out_vs_q    <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      read_init_q <= read_init_d;
      underflow_q <= underflow_d;
      vs_prev_q   <= vpg_vs;
      out_de_q    <= vpg_de;
      out_hs_q    <= vpg_hs;
      out_vs_q    <= vpg_vs;
      rd_q        <= pop_c;
    end
  end

  // FIFO q lands one cycle after the pop, in line with the delayed syncs.
  assign out_data  = (rd_q & out_de_q) ?
                     {fifo.fifo_data[29:22], fifo.fifo_data[19:12], fifo.fifo_data[9:2]} : 24'h0;

  assign read_init = read_init_q;
  assign out_de    = out_de_q;
  assign out_hs    = out_hs_q;
  assign out_vs    = out_vs_q;
  assign pix_cnt   = pix_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign underflow = underflow_q;
  assign state     = state_q;

  logic unused_fifo_bits;
  assign unused_fifo_bits = &{1'b0, fifo.fifo_data[31:30], fifo.fifo_data[21:20],
                              fifo.fifo_data[11:10], fifo.fifo_data[1:0]};

endmodule

// File: tb/tb_dvi_frame_reader.sv
// Directed bench for dvi_frame_reader with a simple behavioural read FIFO.
module tb_dvi_frame_reader;

  logic        dvi_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        vpg_de  = 1'b0;
  logic        vpg_hs  = 1'b0;
  logic        vpg_vs  = 1'b0;
  logic        read_init, out_de, out_hs, out_vs, underflow;
  logic [23:0] out_data;
  logic [19:0] pix_cnt;
  logic [15:0] frame_cnt;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  dvi_frame_reader_if #(.USEDW_W(9)) ifc ();

  dvi_frame_reader #(.FRAME_SIZE(640), .PREFILL(512), .USEDW_W(9)) dut (
    .dvi_clk   (dvi_clk),
    .reset     (reset),
    .vpg_de    (vpg_de),
    .vpg_hs    (vpg_hs),
    .vpg_vs    (vpg_vs),
    .fifo      (ifc),
    .read_init (read_init),
    .out_de    (out_de),
    .out_hs    (out_hs),
    .out_vs    (out_vs),
    .out_data  (out_data),
    .pix_cnt   (pix_cnt),
    .frame_cnt (frame_cnt),
    .underflow (underflow),
    .state     (state)
  );

  always #5 dvi_clk = ~dvi_clk;

  // Behavioural FIFO: words preloaded by the stimulus, popped on rdreq.
  logic [31:0] mem [0:2047];
  logic [10:0] wr_ptr = '0;
  logic [10:0] rd_ptr = '0;
  logic        force_empty = 1'b0;
  logic [8:0]  usedw = 9'd511;
  int          pop_cnt = 0;
  int          viol_cnt = 0;

  assign ifc.fifo_empty   = force_empty | (rd_ptr == wr_ptr);
  assign ifc.fifo_rdusedw = usedw;

  initial ifc.fifo_data = 32'h0;

  always @(posedge dvi_clk) begin
    if (ifc.fifo_rdreq) begin
      if (ifc.fifo_empty) viol_cnt <= viol_cnt + 1;
      ifc.fifo_data <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 11'd1;
      pop_cnt       <= pop_cnt + 1;
    end
  end

  localparam logic [31:0] WORD_A = {2'b00, 10'h3FC, 10'h004, 10'h200};
  localparam logic [31:0] WORD_B = {2'b00, 10'h155, 10'h2AA, 10'h0FF};
  localparam logic [23:0] RGB_A  = 24'hFF0180;
  localparam logic [23:0] RGB_B  = 24'h55AA3F;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge dvi_clk);
    #1;
  endtask

  typedef struct {
    logic [9:0] lvl;
    logic       vs;
    logic       de;
    logic       exp_ri;
    logic [1:0] exp_st;
    logic       exp_rd;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset release through prefill into ACTIVE; level 512 is a full FIFO.
    tbl[0] = '{10'd511, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[1] = '{10'd511, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[2] = '{10'd512, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[3] = '{10'd512, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[4] = '{10'd512, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[5] = '{10'd512, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};

    for (int i = 0; i < 640; i++) mem[i] = WORD_A;
    for (int i = 640; i < 1280; i++) mem[i] = WORD_B;
    wr_ptr = 11'd1280;

    // 1: reset state, then the tabled startup sequence
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_read_init", 32'(read_init), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_rdreq", 32'(ifc.fifo_rdreq), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      usedw  = tbl[i].lvl[8:0];
      vpg_vs = tbl[i].vs;
      vpg_de = tbl[i].de;
      #1;
      chk($sformatf("v%0d_read_init", i), 32'(read_init), 32'(tbl[i].exp_ri));
      chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].exp_st));
      chk($sformatf("v%0d_rdreq", i), 32'(ifc.fifo_rdreq), 32'(tbl[i].exp_rd));
    end
    chk("active_pix_start", 32'(pix_cnt), 0);

    // 2: one full 640-pixel line
    for (int i = 0; i < 640; i++) begin
      tick();
      if (i > 0) chk("line_out_data", 32'(out_data), 32'(RGB_A));
      vpg_vs = 1'b0;
      vpg_de = 1'b1;
      #1;
      chk("line_rdreq", 32'(ifc.fifo_rdreq), 1);
    end
    tick();
    chk("line_last_data", 32'(out_data), 32'(RGB_A));
    vpg_de = 1'b0;
    #1;
    chk("line_pix_cnt", 32'(pix_cnt), 640);
    chk("line_pops", 32'(pop_cnt), 640);
    tick(); vpg_hs = 1'b1;
    tick(); chk("hs_delay_hi", 32'(out_hs), 1); vpg_hs = 1'b0;
    tick(); chk("hs_delay_lo", 32'(out_hs), 0);
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j > 0) chk("over_out_data", 32'(out_data), 0);
      vpg_de = 1'b1;
      #1;
      chk("over_rdreq", 32'(ifc.fifo_rdreq), 0);
    end
    tick(); vpg_de = 1'b0;
    chk("over_pops", 32'(pop_cnt), 640);

    // 3: vs_rise in ACTIVE with de high
    tick(); vpg_vs = 1'b1; vpg_de = 1'b1; #1;
    chk("vs_rdreq", 32'(ifc.fifo_rdreq), 0);
    tick();
    chk("vs_frame_cnt", 32'(frame_cnt), 1);
    chk("vs_pix_cnt", 32'(pix_cnt), 0);
    chk("vs_read_init", 32'(read_init), 1);
    chk("vs_out_de", 32'(out_de), 1);
    chk("vs_out_vs", 32'(out_vs), 1);
    chk("vs_black", 32'(out_data), 0);
    vpg_de = 1'b0;
    tick();
    chk("vs_read_init_end", 32'(read_init), 0);
    chk("vs_state", 32'(state), 3);
    vpg_vs = 1'b0;

    // 4: underflow at pixel 100
    for (int i = 0; i < 100; i++) begin
      tick(); vpg_de = 1'b1;
    end
    tick();
    chk("uf_prev_data", 32'(out_data), 32'(RGB_B));
    chk("uf_pix_cnt", 32'(pix_cnt), 100);
    force_empty = 1'b1;
    usedw = 9'd511;
    #1;
    chk("uf_rdreq", 32'(ifc.fifo_rdreq), 0);
    tick();
    chk("uf_state", 32'(state), 1);
    chk("uf_flag", 32'(underflow), 1);
    chk("uf_black", 32'(out_data), 0);
    chk("uf_out_de", 32'(out_de), 1);
    chk("uf_no_init", 32'(read_init), 0);
    force_empty = 1'b0;
    vpg_de = 1'b0;
    tick();
    chk("uf_prefill_hold", 32'(state), 1);
    usedw = 9'd0;
    tick();
    chk("uf_wait_vs", 32'(state), 2);
    vpg_de = 1'b1; #1;
    chk("uf_wait_rdreq", 32'(ifc.fifo_rdreq), 0);
    tick(); vpg_de = 1'b0; vpg_vs = 1'b1;
    tick();
    chk("uf_resume_state", 32'(state), 3);
    chk("uf_resume_pix", 32'(pix_cnt), 0);
    chk("uf_resume_frame", 32'(frame_cnt), 1);
    chk("uf_sticky", 32'(underflow), 1);

    // 5: async reset mid-line
    for (int i = 0; i < 300; i++) begin
      tick(); vpg_vs = 1'b0; vpg_de = 1'b1;
    end
    tick();
    chk("mid_pix_cnt", 32'(pix_cnt), 300);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_pix", 32'(pix_cnt), 0);
    chk("arst_frame", 32'(frame_cnt), 0);
    chk("arst_underflow", 32'(underflow), 0);
    chk("arst_out_de", 32'(out_de), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_rdreq", 32'(ifc.fifo_rdreq), 0);
    vpg_de = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rel_read_init", 32'(read_init), 1);
    chk("rel_state", 32'(state), 1);
    tick();
    chk("rel_read_init_end", 32'(read_init), 0);
    chk("rel_state2", 32'(state), 2);

    // 6: frame counter wrap
    vpg_vs = 1'b1;
    tick();
    chk("wrap_active", 32'(state), 3);
    vpg_vs = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); vpg_vs = 1'b1;
      tick(); vpg_vs = 1'b0;
    end
    chk("wrap_count3", 32'(frame_cnt), 3);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    tick();
    chk("wrap_preset", 32'(frame_cnt), 32'h0000FFFF);
    vpg_vs = 1'b1;
    tick();
    chk("wrap_zero", 32'(frame_cnt), 0);
    chk("wrap_underflow", 32'(underflow), 0);
    chk("wrap_read_init", 32'(read_init), 1);
    vpg_vs = 1'b0;
    tick();

    chk("rdreq_while_empty", 32'(viol_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
